// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters. The fetch-side lookup is
// combinational. The EX-side resolution drives the mispredict/recover outputs
// and updates the table and the statistics counters at the clock edge.
module branch_predictor #(
    parameter int ENTRIES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC_IF,
    output logic        predict_br,
    output logic [31:0] predict_target,
    input  logic        bubbleE,
    input  logic        br_EX,
    input  logic        br_taken_EX,
    input  logic [31:0] PC_EX,
    input  logic [31:0] br_target_EX,
    input  logic        predict_br_EX,
    output logic        mispredict,
    output logic [31:0] recover_pc,
    output logic [31:0] br_count,
    output logic [31:0] miss_count
);
    localparam int IDX  = $clog2(ENTRIES);
    localparam int TAGW = 32 - IDX - 2;

    logic            r_valid  [ENTRIES];
    logic [TAGW-1:0] r_tag    [ENTRIES];
    logic [31:0]     r_target [ENTRIES];
    logic [1:0]      r_ctr    [ENTRIES];
    logic [31:0]     r_br_count;
    logic [31:0]     r_miss_count;

    logic [IDX-1:0]  w_if_idx;
    logic [TAGW-1:0] w_if_tag;
    logic            w_if_hit;
    logic [IDX-1:0]  w_ex_idx;
    logic [TAGW-1:0] w_ex_tag;
    logic            w_ex_hit;
    logic            w_upd;
    logic [1:0]      w_ctr_cur;
    logic [1:0]      w_ctr_next;
    logic            w_unused_ok;

    // Byte-offset bits never take part in indexing or tagging.
    assign w_unused_ok = ^{PC_IF[1:0], PC_EX[1:0]};

    // Fetch-side lookup. It reads the registered table, so a same-cycle
    // update is not visible until the next cycle.
    assign w_if_idx       = PC_IF[IDX+1:2];
    assign w_if_tag       = PC_IF[31:IDX+2];
    assign w_if_hit       = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    assign predict_br     = w_if_hit && r_ctr[w_if_idx][1];
    assign predict_target = w_if_hit ? r_target[w_if_idx] : (PC_IF + 32'd4);

    // EX-side resolution
    assign w_ex_idx   = PC_EX[IDX+1:2];
    assign w_ex_tag   = PC_EX[31:IDX+2];
    assign w_ex_hit   = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
    assign w_upd      = br_EX && !bubbleE && !rst;
    assign mispredict = br_EX && !bubbleE && (predict_br_EX != br_taken_EX);
    assign recover_pc = br_taken_EX ? br_target_EX : (PC_EX + 32'd4);

    // Saturating counter step for the entry being updated
    assign w_ctr_cur = r_ctr[w_ex_idx];
    always_comb begin
        w_ctr_next = w_ctr_cur;
        if (br_taken_EX) begin
            if (w_ctr_cur != 2'b11) w_ctr_next = w_ctr_cur + 2'b01;
        end else begin
            if (w_ctr_cur != 2'b00) w_ctr_next = w_ctr_cur - 2'b01;
        end
    end

    // Table update: train on a hit, allocate on a taken miss, ignore a
    // not-taken miss. Reset wins and drops any simultaneous update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= 2'b01;
            end
        end else if (w_upd) begin
            if (w_ex_hit) begin
                r_ctr[w_ex_idx] <= w_ctr_next;
                if (br_taken_EX) r_target[w_ex_idx] <= br_target_EX;
            end else if (br_taken_EX) begin
                r_valid[w_ex_idx]  <= 1'b1;
                r_tag[w_ex_idx]    <= w_ex_tag;
                r_target[w_ex_idx] <= br_target_EX;
                r_ctr[w_ex_idx]    <= 2'b10;
            end
        end
    end

    // Statistics counters, wrapping modulo 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            r_br_count   <= 32'd0;
            r_miss_count <= 32'd0;
        end else begin
            if (w_upd)      r_br_count   <= r_br_count + 32'd1;
            if (mispredict) r_miss_count <= r_miss_count + 32'd1;
        end
    end

    assign br_count   = r_br_count;
    assign miss_count = r_miss_count;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed vector table for the corner cases, then a randomized run checked
// against an array-based behavioural model of the BTB.
module tb_branch_predictor;
    localparam int ENTRIES = 16;
    localparam int IDXB    = 4;

    logic        clk;
    logic        rst;
    logic [31:0] PC_IF;
    logic        predict_br;
    logic [31:0] predict_target;
    logic        bubbleE;
    logic        br_EX;
    logic        br_taken_EX;
    logic [31:0] PC_EX;
    logic [31:0] br_target_EX;
    logic        predict_br_EX;
    logic        mispredict;
    logic [31:0] recover_pc;
    logic [31:0] br_count;
    logic [31:0] miss_count;

    int checks   = 0;
    int failures = 0;

    branch_predictor #(.ENTRIES(ENTRIES)) dut (
        .clk(clk), .rst(rst), .PC_IF(PC_IF),
        .predict_br(predict_br), .predict_target(predict_target),
        .bubbleE(bubbleE), .br_EX(br_EX), .br_taken_EX(br_taken_EX),
        .PC_EX(PC_EX), .br_target_EX(br_target_EX),
        .predict_br_EX(predict_br_EX), .mispredict(mispredict),
        .recover_pc(recover_pc), .br_count(br_count), .miss_count(miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          chk;
        bit          rst;
        bit          bub;
        bit          br;
        bit          tk;
        bit          pex;
        logic [31:0] pc_if;
        logic [31:0] pc_ex;
        logic [31:0] tgt;
        bit          e_pb;
        logic [31:0] e_pt;
        bit          e_mp;
        logic [31:0] e_rpc;
        logic [31:0] e_bc;
        logic [31:0] e_mc;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input int n, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%h expected=%h", name, n, got, exp);
        end
    endtask

    task automatic drive(input bit r, input bit bub, input bit br, input bit tk,
                         input bit pex, input logic [31:0] pif,
                         input logic [31:0] pex_pc, input logic [31:0] tgt);
        rst = r; bubbleE = bub; br_EX = br; br_taken_EX = tk;
        predict_br_EX = pex; PC_IF = pif; PC_EX = pex_pc; br_target_EX = tgt;
    endtask

    // Behavioural model state
    bit          m_valid [ENTRIES];
    int unsigned m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    logic [31:0] m_bc, m_mc;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction
    function automatic int unsigned tag_of(input logic [31:0] pc);
        return pc / (4 * ENTRIES);
    endfunction
    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
        m_bc = 0;
        m_mc = 0;
    endtask

    initial begin
        logic [31:0] e_pt, e_rpc;
        bit e_pb, e_mp, upd, hit;
        int k;
        // chk rst bub br tk pex pc_if pc_ex tgt | pb pt mp rpc bc mc
        vecs[0]  = '{0,1,0,0,0,0, 32'h100, 32'h0,   32'h0,   0, 32'h0,   0, 32'h0,   0, 0};
        vecs[1]  = '{1,0,0,0,0,0, 32'h100, 32'h0,   32'h0,   0, 32'h104, 0, 32'h4,   0, 0};
        vecs[2]  = '{1,0,0,1,1,0, 32'h100, 32'h100, 32'h200, 0, 32'h104, 1, 32'h200, 0, 0};
        vecs[3]  = '{1,0,0,0,0,0, 32'h100, 32'h100, 32'h0,   1, 32'h200, 0, 32'h104, 1, 1};
        vecs[4]  = '{1,0,0,1,0,1, 32'h100, 32'h100, 32'h200, 1, 32'h200, 1, 32'h104, 1, 1};
        vecs[5]  = '{1,0,0,0,0,0, 32'h100, 32'h100, 32'h0,   0, 32'h200, 0, 32'h104, 2, 2};
        vecs[6]  = '{1,0,0,1,0,0, 32'h100, 32'h100, 32'h200, 0, 32'h200, 0, 32'h104, 2, 2};
        vecs[7]  = '{1,0,0,1,1,0, 32'h100, 32'h100, 32'h300, 0, 32'h200, 1, 32'h300, 3, 2};
        vecs[8]  = '{1,0,0,1,1,0, 32'h100, 32'h100, 32'h300, 0, 32'h300, 1, 32'h300, 4, 3};
        vecs[9]  = '{1,0,0,0,0,0, 32'h100, 32'h100, 32'h0,   1, 32'h300, 0, 32'h104, 5, 4};
        vecs[10] = '{1,0,1,1,0,1, 32'h100, 32'h100, 32'h0,   1, 32'h300, 0, 32'h104, 5, 4};
        vecs[11] = '{1,0,0,0,0,0, 32'h100, 32'h100, 32'h0,   1, 32'h300, 0, 32'h104, 5, 4};
        vecs[12] = '{1,0,0,1,1,0, 32'h140, 32'h140, 32'h500, 0, 32'h144, 1, 32'h500, 5, 4};
        vecs[13] = '{1,0,0,0,0,0, 32'h100, 32'h100, 32'h0,   0, 32'h104, 0, 32'h104, 6, 5};
        vecs[14] = '{1,0,0,0,0,0, 32'h140, 32'h100, 32'h0,   1, 32'h500, 0, 32'h104, 6, 5};
        vecs[15] = '{1,1,0,1,1,0, 32'h140, 32'h100, 32'h600, 1, 32'h500, 1, 32'h600, 6, 5};
        vecs[16] = '{1,0,0,0,0,0, 32'h140, 32'h100, 32'h0,   0, 32'h144, 0, 32'h104, 0, 0};
        vecs[17] = '{1,0,0,0,0,0, 32'h100, 32'h100, 32'h0,   0, 32'h104, 0, 32'h104, 0, 0};
        vecs[18] = '{1,0,0,1,0,0, 32'h100, 32'hFFFFFFFC, 32'h0, 0, 32'h104, 0, 32'h0, 0, 0};
        vecs[19] = '{1,0,0,0,0,0, 32'hFFFFFFFC, 32'h0, 32'h0, 0, 32'h0,   0, 32'h4,   1, 0};

        drive(1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        #1;
        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].rst, vecs[i].bub, vecs[i].br, vecs[i].tk, vecs[i].pex,
                  vecs[i].pc_if, vecs[i].pc_ex, vecs[i].tgt);
            #1;
            if (vecs[i].chk) begin
                check("vec_predict_br",     i, {31'd0, predict_br}, {31'd0, vecs[i].e_pb});
                check("vec_predict_target", i, predict_target, vecs[i].e_pt);
                check("vec_mispredict",     i, {31'd0, mispredict}, {31'd0, vecs[i].e_mp});
                check("vec_recover_pc",     i, recover_pc, vecs[i].e_rpc);
                check("vec_br_count",       i, br_count, vecs[i].e_bc);
                check("vec_miss_count",     i, miss_count, vecs[i].e_mc);
            end
            @(posedge clk);
            #1;
        end

        // Randomized run against the model
        drive(1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 15,
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                  32'($urandom_range(0, 4 * ENTRIES - 1) * 4),
                  32'($urandom_range(0, 4 * ENTRIES - 1) * 4),
                  32'($urandom_range(0, 32'h3FFF) * 4));
            if ($urandom_range(0, 9) == 0) PC_EX = 32'hFFFFFFFC;
            #1;
            k     = idx_of(PC_IF);
            e_pb  = m_hit(PC_IF) && (m_ctr[k] >= 2);
            e_pt  = m_hit(PC_IF) ? m_tgt[k] : PC_IF + 32'd4;
            e_mp  = br_EX && !bubbleE && (predict_br_EX != br_taken_EX);
            e_rpc = br_taken_EX ? br_target_EX : PC_EX + 32'd4;
            check("rnd_predict_br",     n, {31'd0, predict_br}, {31'd0, e_pb});
            check("rnd_predict_target", n, predict_target, e_pt);
            check("rnd_mispredict",     n, {31'd0, mispredict}, {31'd0, e_mp});
            check("rnd_recover_pc",     n, recover_pc, e_rpc);
            check("rnd_br_count",       n, br_count, m_bc);
            check("rnd_miss_count",     n, miss_count, m_mc);
            // Advance the model to post-edge state
            upd = br_EX && !bubbleE && !rst;
            if (rst) begin
                model_reset();
            end else begin
                k   = idx_of(PC_EX);
                hit = m_hit(PC_EX);
                if (upd && hit) begin
                    if (br_taken_EX) begin
                        m_ctr[k] = (m_ctr[k] == 3) ? 3 : m_ctr[k] + 1;
                        m_tgt[k] = br_target_EX;
                    end else begin
                        m_ctr[k] = (m_ctr[k] == 0) ? 0 : m_ctr[k] - 1;
                    end
                end else if (upd && br_taken_EX) begin
                    m_valid[k] = 1'b1;
                    m_tag[k]   = tag_of(PC_EX);
                    m_tgt[k]   = br_target_EX;
                    m_ctr[k]   = 2;
                end
                if (upd) m_bc = m_bc + 1;
                if (e_mp) m_mc = m_mc + 1;
            end
            @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have these ports (name, direction, width, meaning), clock and reset first:
- clk, in, 1: single clock; all state updates on posedge.
- rst, in, 1: reset, synchronous, active-high.
- PC_IF, in, 32: fetch address, used for lookup.
- predict_br, out, 1: predicted taken for PC_IF; fed to the ID/EX chain as predict_br_ID.
- predict_target, out, 32: predicted target for PC_IF; valid only when predict_br=1.
- bubbleE, in, 1: EX-stage bubble; when high, suppresses all updates.
- br_EX, in, 1: the instruction in EX is a conditional branch.
- br_taken_EX, in, 1: resolved outcome in EX.
- PC_EX, in, 32: EX instruction address.
- br_target_EX, in, 32: resolved branch target.
- predict_br_EX, in, 1: prediction carried down the pipe for the EX instruction.
- mispredict, out, 1: redirect request to the hazard unit.
- recover_pc, out, 32: correct next PC when mispredict=1.
- br_count, out, 32: resolved-branch counter.
- miss_count, out, 32: mispredict counter.
REQ-002 SHALL use the parameter ENTRIES, default 64 (power of two), giving the number of BTB entries. IDX=log2(ENTRIES).

Function
REQ-003 SHALL hold per entry: a valid bit, tag PC[31:IDX+2], target[31:0] and a 2-bit counter (00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T).
REQ-004 Lookup SHALL be combinational, zero latency: index=PC_IF[IDX+1:2]; hit=valid & tag match.
REQ-005 predict_br SHALL be hit & counter[1]; predict_target SHALL be the stored target on a hit, else PC_IF+4.
REQ-006 An update SHALL occur at posedge when upd=br_EX & ~bubbleE & ~rst; the entry is indexed by PC_EX.
REQ-007 Update on a hit SHALL increment the counter when taken and decrement it when not taken, saturating at 11 and 00; on taken, target SHALL be overwritten with br_target_EX.
REQ-008 Update on a miss with taken SHALL allocate the entry (replacing any previous contents): valid=1, tag, target=br_target_EX, counter=10.
REQ-009 Update on a miss with not taken SHALL leave the table unchanged.
REQ-010 mispredict SHALL be combinational: br_EX & ~bubbleE & (predict_br_EX != br_taken_EX).
REQ-011 recover_pc SHALL be br_target_EX when br_taken_EX=1, else PC_EX+4 (32-bit, wraps modulo 2^32).
REQ-012 If a lookup and an update hit the same index in one cycle, the lookup SHALL return pre-update contents; the new contents SHALL be visible the next cycle.
REQ-013 br_count SHALL increment by 1 per upd cycle; miss_count SHALL increment by 1 per cycle where mispredict=1; both SHALL wrap 0xFFFFFFFF->0.
REQ-014 Non-branch instructions in EX (br_EX=0) SHALL produce no state change and mispredict=0.

Reset
REQ-015 At posedge with rst=1 the block SHALL clear all valid bits, set all counters to 01, and clear br_count and miss_count to 0; tags and targets are don't-care.
REQ-016 rst SHALL take priority over a simultaneous update; the update is dropped.
REQ-017 After reset, predict_br SHALL be 0 for every PC_IF until an allocation occurs.

Verification
REQ-018 Reset, then PC_IF=0x100 -> predict_br=0, predict_target=0x104, br_count=0.
REQ-019 Taken branch at PC_EX=0x100, target 0x200, predict_br_EX=0 -> mispredict=1, recover_pc=0x200; next cycle PC_IF=0x100 -> predict_br=1, predict_target=0x200, miss_count=1.
REQ-020 Same branch updated not-taken twice -> counter goes 10->01->00; predict_br=0 after the first update; then two taken updates -> predict_br=1 again.
REQ-021 Aliasing: allocate 0x100, then a taken branch at 0x100+4*ENTRIES -> entry replaced; PC_IF=0x100 -> predict_br=0.
REQ-022 bubbleE=1 with br_EX=1 and a mispredicting outcome -> mispredict=0, no table change, counters unchanged.
REQ-023 rst asserted in the same cycle as a taken update -> table empty and counters 0 the next cycle.
